// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding, error codes and default widths
// for the runtime program loader of the 8-bit accumulator CPU.
package prog_loader_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream valid/ready handshake feeding the loader.
// master drives bytes, slave (the loader) returns in_ready.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/prog_loader_csum.sv
// prog_loader_csum: modulo-2^W running sum with clear and add enable.
// zero_nx tells whether the sum would be zero once din is added.
module prog_loader_csum
    import prog_loader_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         add_en,
    input  logic [W-1:0] din,
    output logic         zero_nx
);

    logic [W-1:0] acc;
    logic [W-1:0] sum;

    assign sum     = acc + din;
    assign zero_nx = (sum == '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a header/data/checksum packet into program memory
// and releases the CPU. Optional idle timeout: PROG_LOADER_TIMEOUT_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int START_ADDR  = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    prog_loader_if.slave      stream,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] pc_init,
    output logic              cpu_run,
    output logic              busy,
    output logic              load_err,
    output logic [1:0]        err_code
);

    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("prog_loader: TIMEOUT_CYC must be at least 1");
    end

    state_t            state;
    logic [3:0]        cnt;
    logic [3:0]        cnt_last;
    logic [ADDR_W-1:0] pc_shadow;
    logic              in_ready_q;
    logic              xfer;
    logic              start_ok;
    logic              timeout;
    logic              zero_nx;

    assign stream.in_ready = in_ready_q;
    assign busy            = in_ready_q;
    assign xfer            = stream.in_valid && in_ready_q;
    assign start_ok        = start &&
                             (state == IDLE || state == DONE || state == ERR);

    prog_loader_csum #(
        .W(DATA_W)
    ) u_csum (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_ok),
        .add_en (xfer),
        .din    (stream.in_data),
        .zero_nx(zero_nx)
    );

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Fires on the edge where the idle count would reach TIMEOUT_CYC.
    assign timeout = in_ready_q && !xfer &&
                     (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !in_ready_q || xfer || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pc_init    <= '0;
            cpu_run    <= 1'b0;
            load_err   <= 1'b0;
            err_code   <= ERR_NONE;
            cnt        <= '0;
            cnt_last   <= '0;
            pc_shadow  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                state      <= HDR;
                in_ready_q <= 1'b1;
                cpu_run    <= 1'b0;
                pc_init    <= '0;
                load_err   <= 1'b0;
                err_code   <= ERR_NONE;
                cnt        <= '0;
            end else if (timeout) begin
                state      <= ERR;
                in_ready_q <= 1'b0;
                load_err   <= 1'b1;
                err_code   <= ERR_TIMEOUT;
            end else if (xfer) begin
                unique case (state)
                    HDR: begin
                        cnt_last  <= stream.in_data[3:0];
                        pc_shadow <= ADDR_W'(stream.in_data[7:4]);
                        cnt       <= '0;
                        state     <= DATA;
                    end
                    DATA: begin
                        // Address wraps naturally at the memory depth.
                        mem_we    <= 1'b1;
                        mem_addr  <= ADDR_W'(START_ADDR) + ADDR_W'(cnt);
                        mem_wdata <= stream.in_data;
                        cnt       <= cnt + 1'b1;
                        if (cnt == cnt_last) begin
                            state <= CSUM;
                        end
                    end
                    CSUM: begin
                        in_ready_q <= 1'b0;
                        if (zero_nx) begin
                            state   <= DONE;
                            pc_init <= pc_shadow;
                            cpu_run <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: two loaders (START_ADDR 0 and 14) fed the same stream,
// checked against a packet-level model of writes and final status.
module tb_prog_loader;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       tv    = 1'b0;
    logic [7:0] td    = 8'h00;

    int n_chk  = 0;
    int n_fail = 0;

    wr_t        q0[$];
    wr_t        q1[$];
    logic [7:0] pay[$];

    logic       we0, we1, run0, run1, busy0, busy1, err0, err1;
    logic [3:0] a0, a1, pc0, pc1;
    logic [7:0] d0, d1;
    logic [1:0] ec0, ec1;

    always #5 clk = ~clk;

    prog_loader_if #(.DATA_W(8)) s0 ();
    prog_loader_if #(.DATA_W(8)) s1 ();

    assign s0.in_valid = tv;
    assign s0.in_data  = td;
    assign s1.in_valid = tv;
    assign s1.in_data  = td;

    prog_loader #(
        .ADDR_W(4), .DATA_W(8), .START_ADDR(0), .TIMEOUT_CYC(8)
    ) u0 (
        .clk(clk), .rst(rst), .start(start), .stream(s0),
        .mem_we(we0), .mem_addr(a0), .mem_wdata(d0), .pc_init(pc0),
        .cpu_run(run0), .busy(busy0), .load_err(err0), .err_code(ec0)
    );

    prog_loader #(
        .ADDR_W(4), .DATA_W(8), .START_ADDR(14), .TIMEOUT_CYC(8)
    ) u1 (
        .clk(clk), .rst(rst), .start(start), .stream(s1),
        .mem_we(we1), .mem_addr(a1), .mem_wdata(d1), .pc_init(pc1),
        .cpu_run(run1), .busy(busy1), .load_err(err1), .err_code(ec1)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write must match the next one the model expects, in order.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (we0) begin
            if (q0.size() == 0) chk("wr0_unexpected", 16'(we0), 16'h0);
            else begin
                e = q0.pop_front();
                chk("wr0", {4'h0, a0, d0}, {4'h0, e.a, e.d});
            end
        end
        if (we1) begin
            if (q1.size() == 0) chk("wr1_unexpected", 16'(we1), 16'h0);
            else begin
                e = q1.pop_front();
                chk("wr1", {4'h0, a1, d1}, {4'h0, e.a, e.d});
            end
        end
    end

    task automatic status(input string tag, input bit run,
                          input logic [3:0] pc, input bit err,
                          input logic [1:0] code, input bit bsy);
        chk({tag, ".run0"}, 16'(run0), 16'(run));
        chk({tag, ".run1"}, 16'(run1), 16'(run));
        chk({tag, ".pc0"}, 16'(pc0), 16'(pc));
        chk({tag, ".pc1"}, 16'(pc1), 16'(pc));
        chk({tag, ".err0"}, 16'(err0), 16'(err));
        chk({tag, ".err1"}, 16'(err1), 16'(err));
        chk({tag, ".code0"}, 16'(ec0), 16'(code));
        chk({tag, ".code1"}, 16'(ec1), 16'(code));
        chk({tag, ".busy0"}, 16'(busy0), 16'(bsy));
        chk({tag, ".busy1"}, 16'(busy1), 16'(bsy));
        chk({tag, ".ready0"}, 16'(s0.in_ready), 16'(bsy));
        chk({tag, ".ready1"}, 16'(s1.in_ready), 16'(bsy));
    endtask

    task automatic send(input logic [7:0] b);
        bit took;
        took = 1'b0;
        tv = 1'b1;
        td = b;
        for (int k = 0; k < 40 && !took; k++) begin
            took = s0.in_ready;
            @(negedge clk);
        end
        tv = 1'b0;
        chk("send_accepted", 16'(took), 16'h1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hdr_ready", 16'(s0.in_ready), 16'h1);
        chk("hdr_run0", 16'(run0), 16'h0);
        chk("hdr_run1", 16'(run1), 16'h0);
    endtask

    task automatic fill_pay();
        pay.delete();
        for (int i = 0; i < 16; i++) pay.push_back(8'($urandom));
    endtask

    task automatic expect_wr(input int i);
        q0.push_back('{a: 4'(i), d: pay[i]});
        q1.push_back('{a: 4'(14 + i), d: pay[i]});
    endtask

    // mode 0: correct checksum, 1: wrong checksum, 2: use 'fixed'
    task automatic load(input string tag, input logic [7:0] hdr,
                        input int mode, input logic [7:0] fixed,
                        input int gap, input bit mid_start);
        int         n;
        logic [7:0] s;
        logic [7:0] cs;
        n = int'(hdr[3:0]) + 1;
        s = hdr;
        pulse_start();
        send(hdr);
        repeat (gap) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            s = s + pay[i];
            expect_wr(i);
            send(pay[i]);
            if (mid_start && i == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            repeat (gap) @(negedge clk);
        end
        if (mode == 0) cs = 8'(0 - int'(s));
        else if (mode == 1) cs = 8'(0 - int'(s) + $urandom_range(1, 255));
        else cs = fixed;
        send(cs);
        if (8'(s + cs) == 8'h00) status(tag, 1'b1, hdr[7:4], 1'b0, 2'b00, 1'b0);
        else status(tag, 1'b0, 4'h0, 1'b1, 2'b01, 1'b0);
        chk({tag, ".left0"}, 16'(q0.size()), 16'h0);
        chk({tag, ".left1"}, 16'(q1.size()), 16'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cs;
        repeat (3) @(negedge clk);
        status("reset", 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
        chk("reset_we0", 16'(we0), 16'h0);
        chk("reset_we1", 16'(we1), 16'h0);
        rst = 1'b0;
        @(negedge clk);

        pay = '{8'h60, 8'h58, 8'h05};
        load("good", 8'h02, 2, 8'h41, 0, 1'b0);
        load("badcs", 8'h02, 2, 8'h42, 0, 1'b0);

        fill_pay();
        load("wrap_bp", 8'h53, 0, 8'h00, 1, 1'b0);
        load("restart", 8'h2F, 0, 8'h00, 0, 1'b0);
        fill_pay();
        load("mid_start", 8'hA6, 0, 8'h00, 2, 1'b1);

        fill_pay();
        pulse_start();
        send(8'h02);
        expect_wr(0);
        send(pay[0]);
        expect_wr(1);
        send(pay[1]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        status("rst_mid", 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
        chk("rst_mid.we0", 16'(we0), 16'h0);
        chk("rst_mid.we1", 16'(we1), 16'h0);
        chk("rst_mid.left0", 16'(q0.size()), 16'h0);
        @(negedge clk);
        chk("rst_mid.nowr0", 16'(we0), 16'h0);
        fill_pay();
        load("after_rst", 8'h72, 0, 8'h00, 0, 1'b0);

        fill_pay();
        pulse_start();
        send(8'h02);
        expect_wr(0);
        send(pay[0]);
        repeat (7) @(negedge clk);
        chk("stall7.busy", 16'(busy0), 16'h1);
`ifdef PROG_LOADER_TIMEOUT_EN
        @(negedge clk);
        status("timeout", 1'b0, 4'h0, 1'b1, 2'b10, 1'b0);
`else
        repeat (20) @(negedge clk);
        chk("stall.busy", 16'(busy0), 16'h1);
        chk("stall.err", 16'(err0), 16'h0);
        expect_wr(1);
        send(pay[1]);
        expect_wr(2);
        send(pay[2]);
        cs = 8'(0 - int'(8'h02) - int'(pay[0]) - int'(pay[1]) - int'(pay[2]));
        send(cs);
        status("stall_done", 1'b1, 4'h0, 1'b0, 2'b00, 1'b0);
`endif
        chk("stall.left0", 16'(q0.size()), 16'h0);

        for (int t = 0; t < 24; t++) begin
            fill_pay();
            load("rand", 8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0,
                 8'h00, $urandom_range(0, 3), 1'b0);
        end

        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        status("rst_start", 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
